// File: rtl/if_poci.sv
// Peripheral POCI bus bundle shared by the I/O slaves.
// Modport f is the slave (function) side, m the master side.
interface if_poci;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport f (input psel, penable, pwrite, paddr, pwdata,
              output prdata, pready, pslverr);
   modport m (output psel, penable, pwrite, paddr, pwdata,
              input prdata, pready, pslverr);
endinterface

// File: rtl/poci_display_ctrl.sv
// POCI slave driving seven-segment digits and LED banks, with optional hex
// decoding, a tick-based blink engine and PWM brightness dimming.
module poci_display_ctrl #(
   parameter int NUM_HEX  = 4,
   parameter int NUM_LEDG = 8,
   parameter int NUM_LEDR = 10,
   parameter int PRESCALE = 50000,
   parameter int PWM_BITS = 4
) (
   input  logic                     pclk,
   input  logic                     presetn,
   if_poci.f                        bus,
   output logic [NUM_HEX-1:0][6:0]  hex,
   output logic [NUM_LEDG-1:0]      ledg,
   output logic [NUM_LEDR-1:0]      ledr
);

   localparam int PS_W   = $clog2(PRESCALE);
   localparam int HIDX_W = (NUM_HEX > 1) ? $clog2(NUM_HEX) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [6:0]      HEX_LIM = 7'(NUM_HEX);

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   logic                decode_en;
   logic                blink_en;
   logic [7:0]          blink_period;
   logic [PWM_BITS-1:0] brightness;
   logic [NUM_LEDG-1:0] ledg_reg;
   logic [NUM_LEDR-1:0] ledr_reg;
   logic [6:0]          hex_reg [NUM_HEX];

   logic [PS_W-1:0]     presc;
   logic                tick;
   logic [7:0]          blink_cnt;
   logic [7:0]          blink_last;
   logic                phase;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                pwm_on;
   logic                on;
   logic [6:0]          seg [NUM_HEX];

   logic [9:0]          word;
   logic [5:0]          hex_idx;
   logic [HIDX_W-1:0]   hsel;
   logic                hex_hit;
   logic                mapped;
   logic                access;
   logic                wr;
   logic                rd;
   logic                ctrl_wr;
   logic [31:0]         rdata;
   logic                unused_bits;

   // Word-aligned decode of the low 12 address bits; HEX window starts at 0x100.
   assign word    = bus.paddr[11:2];
   assign hex_idx = word[5:0];
   assign hsel    = hex_idx[HIDX_W-1:0];
   assign hex_hit = (word[9:6] == 4'b0001) && ({1'b0, hex_idx} < HEX_LIM);
   assign mapped  = (word < 10'd4) || hex_hit;
   assign access  = bus.psel & bus.penable;
   assign wr      = access & bus.pwrite;
   assign rd      = bus.psel & ~bus.pwrite;
   assign ctrl_wr = wr && (word == 10'd0);

   assign unused_bits = ^{bus.paddr[31:12], bus.paddr[1:0], bus.pwdata};

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         decode_en    <= 1'b0;
         blink_en     <= 1'b0;
         blink_period <= 8'd1;
         brightness   <= '1;
         ledg_reg     <= '0;
         ledr_reg     <= '0;
         for (int i = 0; i < NUM_HEX; i++) hex_reg[i] <= '0;
      end else begin
         if (ctrl_wr) begin
            decode_en    <= bus.pwdata[0];
            blink_en     <= bus.pwdata[1];
            blink_period <= bus.pwdata[15:8];
            brightness   <= bus.pwdata[16 +: PWM_BITS];
         end
         if (wr && word == 10'd1) ledg_reg <= bus.pwdata[NUM_LEDG-1:0];
         if (wr && word == 10'd2) ledr_reg <= bus.pwdata[NUM_LEDR-1:0];
         if (wr && hex_hit)       hex_reg[hsel] <= bus.pwdata[6:0];
      end
   end

   always_comb begin
      rdata = '0;
      if (rd) begin
         if (hex_hit) begin
            rdata[6:0] = hex_reg[hsel];
         end else begin
            case (word)
               10'd0: begin
                  rdata[0]             = decode_en;
                  rdata[1]             = blink_en;
                  rdata[15:8]          = blink_period;
                  rdata[16 +: PWM_BITS] = brightness;
               end
               10'd1:   rdata[NUM_LEDG-1:0] = ledg_reg;
               10'd2:   rdata[NUM_LEDR-1:0] = ledr_reg;
               10'd3: begin
                  rdata[0]    = phase;
                  rdata[15:8] = blink_cnt;
               end
               default: rdata = '0;
            endcase
         end
      end
   end

   assign bus.prdata  = rdata;
   assign bus.pready  = 1'b1;
   assign bus.pslverr = access & ~mapped;

   // A CTRL write restarts the blink timing and takes priority over a tick.
   assign tick       = (presc == PS_LAST);
   assign blink_last = (blink_period == 8'd0) ? 8'd0 : blink_period - 8'd1;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         presc     <= '0;
         blink_cnt <= '0;
         phase     <= 1'b1;
         pwm_cnt   <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (ctrl_wr || tick) presc <= '0;
         else                 presc <= presc + 1'b1;
         if (ctrl_wr || !blink_en) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
         end else if (tick) begin
            if (blink_cnt == blink_last) begin
               blink_cnt <= '0;
               phase     <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + 8'd1;
            end
         end
      end
   end

   assign pwm_on = (&brightness) | (pwm_cnt < brightness);
   assign on     = phase & pwm_on;

   always_comb begin
      for (int i = 0; i < NUM_HEX; i++)
         seg[i] = decode_en ? seg_decode(hex_reg[i][3:0]) : hex_reg[i];
   end

   // Output register stage: segments are active-low, LEDs active-high.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         hex  <= '1;
         ledg <= '0;
         ledr <= '0;
      end else begin
         for (int i = 0; i < NUM_HEX; i++) hex[i] <= ~(seg[i] & {7{on}});
         ledg <= ledg_reg & {NUM_LEDG{on}};
         ledr <= ledr_reg & {NUM_LEDR{on}};
      end
   end

endmodule

// File: tb/tb_poci_display_ctrl.sv
// Scoreboard bench for poci_display_ctrl: expectations are queued as stimulus
// is applied and retired against DUT outputs and read data.
module tb_poci_display_ctrl;

   localparam int NUM_HEX  = 4;
   localparam int NUM_LEDG = 8;
   localparam int NUM_LEDR = 10;
   localparam int PRESCALE = 4;
   localparam int PWM_BITS = 4;

   logic                    pclk;
   logic                    presetn;
   logic [NUM_HEX-1:0][6:0] hex;
   logic [NUM_LEDG-1:0]     ledg;
   logic [NUM_LEDR-1:0]     ledr;

   if_poci bus_if ();

   poci_display_ctrl #(
      .NUM_HEX (NUM_HEX),
      .NUM_LEDG(NUM_LEDG),
      .NUM_LEDR(NUM_LEDR),
      .PRESCALE(PRESCALE),
      .PWM_BITS(PWM_BITS)
   ) dut (
      .pclk   (pclk),
      .presetn(presetn),
      .bus    (bus_if),
      .hex    (hex),
      .ledg   (ledg),
      .ledr   (ledr)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   int n_cmp;
   int n_err;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb_q[$];

   // Bench model of the display registers
   bit         m_dec;
   logic [6:0] m_hex [NUM_HEX];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic observe(input logic [31:0] got);
      exp_t e;
      if (sb_q.size() == 0) begin
         e.tag = "sb_empty";
         e.val = 'x;
      end else begin
         e = sb_q.pop_front();
      end
      chk(e.tag, got, e.val);
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      logic [6:0] tbl [16];
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return tbl[n];
   endfunction

   function automatic logic [31:0] exp_hex();
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < NUM_HEX; i++)
         r[7*i +: 7] = ~(m_dec ? ref_seg(m_hex[i][3:0]) : m_hex[i]);
      return r;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   // All bus tasks start and end 1 ns after a rising edge, so calls chain back-to-back.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic err);
      bus_if.psel    = 1'b1;
      bus_if.pwrite  = 1'b1;
      bus_if.paddr   = a;
      bus_if.pwdata  = d;
      bus_if.penable = 1'b0;
      @(posedge pclk);
      #1 bus_if.penable = 1'b1;
      #2 err = bus_if.pslverr;
      @(posedge pclk);
      #1;
      bus_if.psel    = 1'b0;
      bus_if.penable = 1'b0;
      bus_if.pwrite  = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic err);
      bus_if.psel    = 1'b1;
      bus_if.pwrite  = 1'b0;
      bus_if.paddr   = a;
      bus_if.penable = 1'b0;
      @(posedge pclk);
      #1 bus_if.penable = 1'b1;
      #2;
      d   = bus_if.prdata;
      err = bus_if.pslverr;
      @(posedge pclk);
      #1;
      bus_if.psel    = 1'b0;
      bus_if.penable = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic e;
      bus_write(a, d, e);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rdat;
      logic        err;
      int          on_a, on_b, bad, lit;

      n_cmp = 0;
      n_err = 0;
      m_dec = 1'b0;
      for (int i = 0; i < NUM_HEX; i++) m_hex[i] = '0;
      bus_if.psel    = 1'b0;
      bus_if.penable = 1'b0;
      bus_if.pwrite  = 1'b0;
      bus_if.paddr   = '0;
      bus_if.pwdata  = '0;
      presetn        = 1'b0;

      // Power-on reset
      repeat (3) @(posedge pclk);
      #1;
      expect_val("rst_hex", 32'h0FFF_FFFF);  observe(32'(hex));
      expect_val("rst_ledg", 32'h0);         observe(32'(ledg));
      expect_val("rst_ledr", 32'h0);         observe(32'(ledr));
      #2 presetn = 1'b1;
      step(1);
      expect_val("rst_ctrl", 32'h000F_0100);
      bus_read(32'h000, rdat, err);
      observe(rdat);
      expect_val("rst_status", 32'h0000_0001);
      expect_val("status_rd_err", 32'h0);
      bus_read(32'h00C, rdat, err);
      observe(rdat);
      observe(32'(err));

      // Asynchronous reset mid-operation
      wr(32'h004, 32'hA5);
      expect_val("ledg_a5", 32'hA5);
      step(1);
      observe(32'(ledg));
      #1 presetn = 1'b0;
      #1;
      expect_val("async_rst_ledg", 32'h0);        observe(32'(ledg));
      expect_val("async_rst_hex", 32'h0FFF_FFFF); observe(32'(hex));
      #1 presetn = 1'b1;
      step(1);
      expect_val("async_rst_ctrl", 32'h000F_0100);
      bus_read(32'h000, rdat, err);
      observe(rdat);

      // Decode mode and raw mode
      wr(32'h000, 32'h000F_0001);
      wr(32'h100, 32'h3);
      wr(32'h104, 32'hA);
      m_dec = 1'b1; m_hex[0] = 7'h03; m_hex[1] = 7'h0A;
      expect_val("hex_decode", exp_hex());
      step(1);
      observe(32'(hex));
      expect_val("hex1_readback", 32'h0000_000A);
      bus_read(32'h104, rdat, err);
      observe(rdat);
      wr(32'h000, 32'h000F_0000);
      m_dec = 1'b0;
      expect_val("hex_raw", exp_hex());
      expect_val("hex1_raw_digit", 32'h75);
      step(1);
      observe(32'(hex));
      observe(32'(hex[1]));

      // Unmapped and read-only accesses
      expect_val("err_wr_200", 32'h1);
      bus_write(32'h200, 32'hFFFF_FFFF, err);
      observe(32'(err));
      expect_val("err_wr_hex4", 32'h1);
      bus_write(32'h110, 32'h7F, err);
      observe(32'(err));
      expect_val("status_wr_err", 32'h0);
      bus_write(32'h00C, 32'hFFFF_FFFF, err);
      observe(32'(err));
      expect_val("unmapped_nochange_hex", exp_hex());
      expect_val("unmapped_nochange_ledg", 32'h0);
      step(1);
      observe(32'(hex));
      observe(32'(ledg));
      expect_val("rd_200_data", 32'h0);
      expect_val("rd_200_err", 32'h1);
      bus_read(32'h200, rdat, err);
      observe(rdat);
      observe(32'(err));
      expect_val("status_after_wr", 32'h0000_0001);
      bus_read(32'h00C, rdat, err);
      observe(rdat);

      // Back-to-back LED writes
      wr(32'h004, 32'h3C);
      wr(32'h008, 32'h155);
      expect_val("b2b_ledg", 32'h3C);
      expect_val("b2b_ledr_not_yet", 32'h0);
      observe(32'(ledg));
      observe(32'(ledr));
      expect_val("b2b_ledr", 32'h155);
      step(1);
      observe(32'(ledr));

      // PWM dimming at brightness 4 of 16
      wr(32'h000, 32'h0004_0000);
      wr(32'h004, 32'hFF);
      step(1);
      on_a = 0; on_b = 0; bad = 0;
      for (int k = 0; k < 32; k++) begin
         if (ledg == 8'hFF) begin
            if (k < 16) on_a++;
            else        on_b++;
         end else if (ledg != 8'h00) begin
            bad++;
         end
         step(1);
      end
      expect_val("pwm_on_win0", 32'd4);  observe(32'(on_a));
      expect_val("pwm_on_win1", 32'd4);  observe(32'(on_b));
      expect_val("pwm_partial", 32'd0);  observe(32'(bad));

      wr(32'h000, 32'h0000_0000);
      step(1);
      lit = 0;
      for (int k = 0; k < 20; k++) begin
         if (ledg != 8'h00) lit++;
         step(1);
      end
      expect_val("pwm_zero_dark", 32'd0);
      observe(32'(lit));

      // Blink, period 2 ticks of 4 pclk
      wr(32'h008, 32'h3FF);
      wr(32'h000, 32'h000F_0203);
      for (int k = 1; k <= 32; k++) begin
         expect_val($sformatf("blink_p2_k%0d", k), (((k - 1) / 8) % 2 == 0) ? 32'h3FF : 32'h0);
         step(1);
         observe(32'(ledr));
      end

      // Blink, period 0 behaves as 1 tick
      wr(32'h000, 32'h000F_0003);
      for (int k = 1; k <= 16; k++) begin
         expect_val($sformatf("blink_p0_k%0d", k), (((k - 1) / 4) % 2 == 0) ? 32'h3FF : 32'h0);
         step(1);
         observe(32'(ledr));
      end

      // Counter visible in STATUS after one tick
      wr(32'h000, 32'h000F_0203);
      step(3);
      expect_val("status_cnt1", 32'h0000_0101);
      bus_read(32'h00C, rdat, err);
      observe(rdat);

      // CTRL write lands on the toggling tick edge
      wr(32'h000, 32'h000F_0203);
      step(6);
      wr(32'h000, 32'h000F_0203);
      expect_val("race_status", 32'h0000_0001);
      expect_val("race_err", 32'h0);
      bus_read(32'h00C, rdat, err);
      observe(rdat);
      observe(32'(err));
      expect_val("race_ledr_on", 32'h3FF);
      observe(32'(ledr));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
